// File: rtl/aileron_pkg.sv
// Shared types and default constants for the aileron solenoid driver.
package aileron_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LEFT  = 2'd1,
      ST_RIGHT = 2'd2,
      ST_DEAD  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      SIDE_NONE  = 2'd0,
      SIDE_LEFT  = 2'd1,
      SIDE_RIGHT = 2'd2
   } side_e;

   localparam int MIN_HOLD_DEF  = 4;
   localparam int DEAD_CYC_DEF  = 3;
   localparam int STAGE_DLY_DEF = 2;
   localparam int CNT_W_DEF     = 8;

   // Inputs are already filtered for legality, so at most one side is requested.
   function automatic side_e pick_side(input logic v1e, input logic v1d);
      side_e s;
      s = SIDE_NONE;
      if (v1e)      s = SIDE_LEFT;
      else if (v1d) s = SIDE_RIGHT;
      return s;
   endfunction

endpackage

// File: rtl/aileron_hold_timer.sv
// Loadable down-counter that stops at zero; used for the hold and dead-time timers.
module aileron_hold_timer
   import aileron_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)                   cnt_d = load_val;
      else if (dec && cnt_q != '0) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/aileron_valve_driver.sv
// Solenoid driver: minimum hold, side-to-side dead time, staged second valve, illegal-request flag.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | all solenoids closed, waiting for a legal stage-1 request
//   ST_LEFT  | left stage-1 open (stage-2 per staging), right side closed
//   ST_RIGHT | right stage-1 open (stage-2 per staging), left side closed
//   ST_DEAD  | all closed, dead time running before either side may open
module aileron_valve_driver
   import aileron_pkg::*;
#(
   parameter int MIN_HOLD  = MIN_HOLD_DEF,
   parameter int DEAD_CYC  = DEAD_CYC_DEF,
   parameter int STAGE_DLY = STAGE_DLY_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic req_v1e,
   input  logic req_v2e,
   input  logic req_v1d,
   input  logic req_v2d,
   output logic sol_v1e,
   output logic sol_v2e,
   output logic sol_v1d,
   output logic sol_v2d,
   output logic busy,
   output logic fault
);

   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(MIN_HOLD - 1);
   localparam logic [CNT_W-1:0] DEAD_LD   = CNT_W'(DEAD_CYC - 1);
   localparam logic [CNT_W-1:0] STAGE_LIM = CNT_W'(STAGE_DLY);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] stage_cnt_q, stage_cnt_d, stage_nxt;
   logic             sol_v1e_q, sol_v1e_d, sol_v2e_q, sol_v2e_d;
   logic             sol_v1d_q, sol_v1d_d, sol_v2d_q, sol_v2d_d;
   logic             busy_q, busy_d, fault_q, fault_d;

   logic  illegal, e1, e2, d1, d2, v2_side, enter;
   logic  hold_load, hold_dec, hold_zero, dead_load, dead_dec, dead_zero;
   side_e side;

   aileron_hold_timer #(.CNT_W(CNT_W)) u_hold (
      .clk(clk), .rst(rst), .load(hold_load), .dec(hold_dec),
      .load_val(HOLD_LD), .zero(hold_zero)
   );

   aileron_hold_timer #(.CNT_W(CNT_W)) u_dead (
      .clk(clk), .rst(rst), .load(dead_load), .dec(dead_dec),
      .load_val(DEAD_LD), .zero(dead_zero)
   );

   always_comb begin
      state_d     = state_q;
      stage_cnt_d = '0;
      sol_v1e_d   = 1'b0;
      sol_v2e_d   = 1'b0;
      sol_v1d_d   = 1'b0;
      sol_v2d_d   = 1'b0;
      hold_load   = 1'b0;
      hold_dec    = 1'b0;
      dead_load   = 1'b0;
      dead_dec    = 1'b0;
      enter       = 1'b0;

      // An illegal combination masks every request for this edge.
      illegal = (req_v1e && req_v1d) || (req_v2e && !req_v1e) || (req_v2d && !req_v1d);
      fault_d = illegal;
      e1 = req_v1e && !illegal;
      e2 = req_v2e && !illegal;
      d1 = req_v1d && !illegal;
      d2 = req_v2d && !illegal;
      side = pick_side(e1, d1);

      v2_side   = (state_q == ST_LEFT) ? e2 : d2;
      stage_nxt = (stage_cnt_q >= STAGE_LIM) ? STAGE_LIM : stage_cnt_q + 1'b1;

      case (state_q)
         ST_IDLE: enter = 1'b1;
         ST_LEFT, ST_RIGHT: begin
            hold_dec = 1'b1;
            if (!((state_q == ST_LEFT) ? e1 : d1) && hold_zero) begin
               state_d   = ST_DEAD;
               dead_load = 1'b1;
            end else begin
               stage_cnt_d = v2_side ? stage_nxt : '0;
               if (state_q == ST_LEFT) begin
                  sol_v1e_d = 1'b1;
                  sol_v2e_d = v2_side && (stage_cnt_d == STAGE_LIM);
               end else begin
                  sol_v1d_d = 1'b1;
                  sol_v2d_d = v2_side && (stage_cnt_d == STAGE_LIM);
               end
            end
         end
         ST_DEAD: begin
            if (dead_zero) enter = 1'b1;
            else           dead_dec = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      if (enter) begin
         case (side)
            SIDE_LEFT: begin
               state_d   = ST_LEFT;
               sol_v1e_d = 1'b1;
               hold_load = 1'b1;
            end
            SIDE_RIGHT: begin
               state_d   = ST_RIGHT;
               sol_v1d_d = 1'b1;
               hold_load = 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         stage_cnt_q <= '0;
         sol_v1e_q   <= 1'b0;
         sol_v2e_q   <= 1'b0;
         sol_v1d_q   <= 1'b0;
         sol_v2d_q   <= 1'b0;
         busy_q      <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         stage_cnt_q <= stage_cnt_d;
         sol_v1e_q   <= sol_v1e_d;
         sol_v2e_q   <= sol_v2e_d;
         sol_v1d_q   <= sol_v1d_d;
         sol_v2d_q   <= sol_v2d_d;
         busy_q      <= busy_d;
         fault_q     <= fault_d;
      end
   end

   assign sol_v1e = sol_v1e_q;
   assign sol_v2e = sol_v2e_q;
   assign sol_v1d = sol_v1d_q;
   assign sol_v2d = sol_v2d_q;
   assign busy    = busy_q;
   assign fault   = fault_q;

endmodule

// File: doc/aileron_valve_driver.md
Name: aileron_valve_driver

Overview:
- Downstream stage of the aileron angle-to-valve decoder. Consumes its four valve requests (v1e, v2e, v1d, v2d) and drives the physical solenoids.
- Enforces a minimum open time, a dead time between the left and right sides, and staged opening of the second valve.
- Rejects illegal request combinations and flags them.

Parameters:
- MIN_HOLD, 4: minimum cycles the stage-1 solenoid of a side stays open once opened (>=1).
- DEAD_CYC, 3: cycles all solenoids stay closed between closing one side and opening either side (>=1).
- STAGE_DLY, 2: consecutive cycles req_v2x must be high in the side state before sol_v2x opens (>=1).
- CNT_W, 8: counter width; must hold max(MIN_HOLD, DEAD_CYC, STAGE_DLY).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, synchronous, active-high
- req_v1e  input  1  left stage-1 request
- req_v2e  input  1  left stage-2 request
- req_v1d  input  1  right stage-1 request
- req_v2d  input  1  right stage-2 request
- sol_v1e  output  1  left stage-1 solenoid (1 = open)
- sol_v2e  output  1  left stage-2 solenoid
- sol_v1d  output  1  right stage-1 solenoid
- sol_v2d  output  1  right stage-2 solenoid
- busy  output  1  1 when state != IDLE
- fault  output  1  illegal request seen on the previous edge

Behaviour:
- All outputs are registered. Any request value other than 1 (0, x, z) counts as not requested. The upstream neutral code 0x0x therefore means "no request".
- Reset: on an rst edge, all sol_* = 0, busy = 0, fault = 0, state = IDLE, all counters = 0. Reset overrides hold and dead time. The first request after reset is serviced on the next edge with no dead time.
- Illegal combination, evaluated every edge:
  - req_v1e and req_v1d both high; or
  - req_v2x high without req_v1x on the same side.
  - When illegal, fault = 1 on that edge and all requests are treated as 0 for that edge. fault returns to 0 on the first edge with a legal combination.
- States: IDLE, LEFT, RIGHT, DEAD.
- IDLE (all sol = 0):
  - Legal req_v1e -> LEFT. sol_v1e = 1 on the same edge; hold_cnt = MIN_HOLD-1.
  - Legal req_v1d -> RIGHT, symmetric.
  - Otherwise stay in IDLE.
- LEFT (sol_v1e = 1, sol_v1d = sol_v2d = 0):
  - hold_cnt decrements each edge while > 0.
  - stage_cnt counts consecutive edges with req_v2e high, saturating at STAGE_DLY. It clears to 0 when req_v2e is low.
  - sol_v2e = 1 once stage_cnt has reached STAGE_DLY and req_v2e is still high. sol_v2e drops on the first edge req_v2e is low, independent of hold.
  - Exit to DEAD when req_v1e is low (or illegal) and hold_cnt == 0. On that edge all sol = 0 and dead_cnt = DEAD_CYC-1.
  - Result: stage 1 stays open at least MIN_HOLD cycles.
- RIGHT: mirror of LEFT using the d-side signals.
- DEAD (all sol = 0):
  - dead_cnt decrements each edge.
  - On the edge where dead_cnt == 0, requests are evaluated exactly as in IDLE and the block enters LEFT, RIGHT or IDLE.
  - Result: all solenoids are closed for exactly DEAD_CYC cycles.
- Invariants: left and right solenoids are never open in the same cycle. sol_v2x = 1 implies sol_v1x = 1.
- Latency: request to sol_v1x is 1 edge from IDLE. Stage 2 opens STAGE_DLY edges after stage 1 when req_v2x is held from the start.
- A request for the same side during DEAD is not serviced early; the full dead time applies.

Decomposition:
- Package aileron_pkg holds:
  - the state enum (IDLE, LEFT, RIGHT, DEAD);
  - the side encoding;
  - the default parameter constants.
- One sub-module, aileron_hold_timer: loadable down-counter, CNT_W wide, with load/value/zero flag. Instantiated twice, once for hold_cnt and once for dead_cnt.
- stage_cnt stays inline.

Test Plan:
- req_v1e=1 and req_v2e=1 held from edge 0 -> sol_v1e=1 after edge 0, sol_v2e=1 after edge 2, busy=1, fault=0.
- req_v1e pulsed for 1 cycle -> sol_v1e high for exactly 4 cycles, then all closed for 3 cycles, busy high for 7 cycles, then IDLE.
- Left held 10 cycles, then req_v1d=1 on the edge req_v1e drops:
  - sol_v1e falls.
  - sol_v1d rises exactly 3 cycles later.
  - No cycle has both sides open.
- From IDLE, req_v1e=req_v1d=1 -> all sol stay 0, fault=1 next edge, fault=0 one edge after req_v1d drops; the same edge opens sol_v1e.
- rst asserted for one cycle during LEFT with sol_v2e=1:
  - Next edge: all sol=0, busy=0.
  - req_v1d applied on the following edge -> sol_v1d=1 with no dead time.
- Inputs 0x0x (neutral) for 5 cycles, and req_v2d=1 alone -> no solenoid opens; fault=1 only for the req_v2d case.
